// File: rtl/cmp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmp_pkg : shared state type and {gt,eq,lt} result encodings for cmp_seq_unit
// Revision: 1.0
// ----------------------------------------------------------------------------
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

endpackage
`default_nettype wire

// File: rtl/cmp_chunk.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmp_chunk : combinational unsigned compare of one CHUNK-bit slice
// Revision: 1.0
// ----------------------------------------------------------------------------
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule
`default_nettype wire

// File: rtl/cmp_seq_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmp_seq_unit : multi-cycle signed/unsigned comparator, MSB chunk first,
//                valid/ready on both sides. Optional macro: CMP_EARLY_EXIT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module cmp_seq_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       cmpout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0]    IDX_MSB = IW'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] TOP_BIT = CHUNK'(1) << (CHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("cmp_seq_unit: WIDTH must be a multiple of CHUNK");
  end

  cmp_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IW-1:0]    r_idx;
  logic             r_decided;
  logic             r_gt;
  logic             r_lt;
  logic             r_res_valid;
  logic [2:0]       r_cmpout;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_flip;
  logic             w_gt;
  logic             w_eq;
  logic             w_gt_n;
  logic             w_lt_n;
  logic             w_last;

  // Operands shift left each cycle, so the chunk under test is always the top slice.
  assign w_flip = r_signed && (r_idx == IDX_MSB);
  assign w_ca   = r_a[WIDTH-1 -: CHUNK] ^ (w_flip ? TOP_BIT : '0);
  assign w_cb   = r_b[WIDTH-1 -: CHUNK] ^ (w_flip ? TOP_BIT : '0);

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (w_ca),
    .b  (w_cb),
    .gt (w_gt),
    .eq (w_eq)
  );

  assign w_gt_n = r_decided ? r_gt : (w_gt & ~w_eq);
  assign w_lt_n = r_decided ? r_lt : (~w_gt & ~w_eq);

`ifdef CMP_EARLY_EXIT_EN
  assign w_last = (r_idx == '0) || (!r_decided && !w_eq);
`else
  assign w_last = (r_idx == '0);
`endif

  assign start_ready = (r_state == IDLE);
  assign res_valid   = r_res_valid;
  assign cmpout      = r_cmpout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_signed    <= 1'b0;
      r_idx       <= '0;
      r_decided   <= 1'b0;
      r_gt        <= 1'b0;
      r_lt        <= 1'b0;
      r_res_valid <= 1'b0;
      r_cmpout    <= CMP_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a       <= a;
            r_b       <= b;
            r_signed  <= is_signed;
            r_idx     <= IDX_MSB;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          r_a       <= r_a << CHUNK;
          r_b       <= r_b << CHUNK;
          r_idx     <= r_idx - IW'(1);
          r_decided <= r_decided | ~w_eq;
          r_gt      <= w_gt_n;
          r_lt      <= w_lt_n;
          if (w_last) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
            r_cmpout    <= {w_gt_n, ~(w_gt_n | w_lt_n), w_lt_n};
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmp_seq_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cmp_seq_unit : directed and random checks of cmp_seq_unit (32/8 and 64/16)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cmp_seq_unit;
  import cmp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        is_signed = 1'b0;
  logic        sv32 = 1'b0, rr32 = 1'b0, sv64 = 1'b0, rr64 = 1'b0;
  logic        srdy32, rv32, srdy64, rv64;
  logic [2:0]  co32, co64;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmp_seq_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(sv32), .start_ready(srdy32),
    .a(a[31:0]), .b(b[31:0]), .is_signed(is_signed),
    .res_valid(rv32), .res_ready(rr32), .cmpout(co32)
  );

  cmp_seq_unit #(.WIDTH(64), .CHUNK(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv64), .start_ready(srdy64),
    .a(a), .b(b), .is_signed(is_signed),
    .res_valid(rv64), .res_ready(rr64), .cmpout(co64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: numeric compare of the operands interpreted per mode.
  function automatic logic [2:0] ref_cmp(input logic [63:0] x, input logic [63:0] y,
                                         input logic s, input int w);
    logic [63:0]        m;
    logic [63:0]        ux, uy;
    logic signed [63:0] sx, sy;
    m  = (w == 64) ? '1 : ((64'h1 << w) - 64'h1);
    ux = x & m;
    uy = y & m;
    sx = $signed(ux << (64 - w)) >>> (64 - w);
    sy = $signed(uy << (64 - w)) >>> (64 - w);
    if (s) return (sx > sy) ? CMP_GT : (sx < sy) ? CMP_LT : CMP_EQ;
    return (ux > uy) ? CMP_GT : (ux < uy) ? CMP_LT : CMP_EQ;
  endfunction

  // Expected cycles from accept to res_valid.
  function automatic int exp_lat(input logic [63:0] x, input logic [63:0] y,
                                 input int w, input int c);
    int          nch;
    int          first;
    logic [63:0] cm;
    nch   = w / c;
    first = nch;
    cm    = (64'h1 << c) - 64'h1;
    for (int i = nch - 1; i >= 0; i--) begin
      if (first == nch && (((x >> (i * c)) & cm) != ((y >> (i * c)) & cm)))
        first = nch - i;
    end
`ifdef CMP_EARLY_EXIT_EN
    return first;
`else
    return (first > 0) ? nch : nch;
`endif
  endfunction

  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic s, input logic [2:0] exp);
    int n;
    chk({tag, "_srdy"}, srdy32, 1);
    a = {32'h0, ta};
    b = {32'h0, tb_};
    is_signed = s;
    sv32 = 1'b1;
    tick();
    sv32 = 1'b0;
    chk({tag, "_busy"}, srdy32, 0);
    n = 0;
    while (!rv32 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat({32'h0, ta}, {32'h0, tb_}, 32, 8));
    chk({tag, "_res"}, co32, exp);
    rr32 = 1'b1;
    tick();
    rr32 = 1'b0;
    chk({tag, "_ret"}, {rv32, srdy32}, 2'b01);
  endtask

  function automatic logic get_sr(input bit w64);
    return w64 ? srdy64 : srdy32;
  endfunction
  function automatic logic get_rv(input bit w64);
    return w64 ? rv64 : rv32;
  endfunction
  function automatic logic [2:0] get_co(input bit w64);
    return w64 ? co64 : co32;
  endfunction

  task automatic rand_run(input bit w64);
    int          w, c, n, lat, prev_lat;
    int unsigned acc, prev_acc;
    logic [63:0] ra, rb, m;
    logic        rs;
    w = w64 ? 64 : 32;
    c = w64 ? 16 : 8;
    m = w64 ? '1 : 64'hFFFF_FFFF;
    prev_lat = 0;
    prev_acc = 0;
    if (w64) begin sv64 = 1'b1; rr64 = 1'b1; end
    else     begin sv32 = 1'b1; rr32 = 1'b1; end
    for (int i = 0; i < 100; i++) begin
      ra = {$urandom, $urandom} & m;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = (ra ^ (64'h1 << $urandom_range(0, w - 1))) & m;
        default: rb = {$urandom, $urandom} & m;
      endcase
      rs = 1'($urandom_range(0, 1));
      a = ra;
      b = rb;
      is_signed = rs;
      chk("rnd_srdy", get_sr(w64), 1);
      tick();
      acc = cyc;
      if (i > 0) chk("rnd_gap", acc - prev_acc, prev_lat + 2);
      lat = exp_lat(ra, rb, w, c);
      n = 0;
      while (!get_rv(w64) && n < 80) begin
        tick();
        n++;
      end
      chk("rnd_lat", n, lat);
      chk("rnd_res", get_co(w64), ref_cmp(ra, rb, rs, w));
      prev_acc = acc;
      prev_lat = lat;
      tick();
    end
    sv32 = 1'b0; rr32 = 1'b0; sv64 = 1'b0; rr64 = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    #3;
    chk("rst_valid", rv32, 0);
    chk("rst_cmpout", co32, CMP_NONE);
    chk("rst_srdy", srdy32, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    do_op("t1_signed",   32'hFFFF_FFFF, 32'h0000_0001, 1'b1, CMP_LT);
    do_op("t1_unsigned", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, CMP_GT);
    do_op("t2_eq_s",     32'h1234_5678, 32'h1234_5678, 1'b1, CMP_EQ);
    do_op("t2_eq_u",     32'h1234_5678, 32'h1234_5678, 1'b0, CMP_EQ);
    do_op("t3_unsigned", 32'h8000_0000, 32'h0000_0000, 1'b0, CMP_GT);
    do_op("t3_signed",   32'h8000_0000, 32'h0000_0000, 1'b1, CMP_LT);
    do_op("lsb_only",    32'h0000_0010, 32'h0000_0011, 1'b0, CMP_LT);

    // Backpressure in DONE with a competing start request.
    a = 64'h10; b = 64'h20; is_signed = 1'b0; sv32 = 1'b1;
    tick();
    sv32 = 1'b0;
    n = 0;
    while (!rv32 && n < 40) begin tick(); n++; end
    chk("bp_first", co32, CMP_LT);
    sv32 = 1'b1;
    a = 64'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", rv32, 1);
      chk("bp_res", co32, CMP_LT);
      chk("bp_srdy", srdy32, 0);
    end
    rr32 = 1'b1;
    tick();
    rr32 = 1'b0;
    sv32 = 1'b0;
    chk("bp_release", {rv32, srdy32}, 2'b01);
    chk("bp_keep", co32, CMP_LT);
    tick();
    chk("bp_noacc", srdy32, 1);

    // Asynchronous reset in the middle of an operation.
    a = 64'h1; b = 64'h2; sv32 = 1'b1;
    tick();
    sv32 = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", rv32, 0);
    chk("abort_cmpout", co32, CMP_NONE);
    chk("abort_srdy", srdy32, 1);
    #1 rst_n = 1'b1;
    tick();
    do_op("t5_after", 32'd5, 32'd7, 1'b0, CMP_LT);

    rand_run(1'b0);
    rand_run(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
